// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution stimulus master.
package conv_pkg;

  localparam int X_W    = 25;
  localparam int CONV_W = 2;

  // Fibonacci LFSR taps for x^25 + x^22 + 1
  localparam int TAP_A = 24;
  localparam int TAP_B = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One LFSR step: feedback bit enters at bit 0
  function automatic logic [X_W-1:0] lfsr_step(input logic [X_W-1:0] x);
    return {x[X_W-2:0], x[TAP_A] ^ x[TAP_B]};
  endfunction

endpackage

// File: rtl/conv_stim_master_if.sv
// Operand/result handshake bundle between the stimulus master and the conv core.
// Signal names are from the master's point of view.
interface conv_stim_master_if;
  import conv_pkg::*;

  logic              o_valid;
  logic              i_ready;
  logic [X_W-1:0]    o_bit_X;
  logic [X_W-1:0]    o_bit_K;
  logic              i_valid;
  logic [CONV_W-1:0] i_conv;
  logic              o_ready;

  modport master (
    output o_valid, o_bit_X, o_bit_K, o_ready,
    input  i_ready, i_valid, i_conv
  );

  modport slave (
    input  o_valid, o_bit_X, o_bit_K, o_ready,
    output i_ready, i_valid, i_conv
  );

endinterface

// File: rtl/lfsr25.sv
// Window generator: loadable 25-bit Fibonacci LFSR that never loads the all-zero lock-up state.
module lfsr25
  import conv_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_arstn,
  input  logic           i_load,
  input  logic [X_W-1:0] i_seed,
  input  logic           i_advance,
  output logic [X_W-1:0] o_x
);

  // Load has priority over advance; a zero seed is replaced by 1
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      o_x <= '0;
    end else if (i_load) begin
      o_x <= (i_seed == '0) ? X_W'(1) : i_seed;
    end else if (i_advance) begin
      o_x <= lfsr_step(o_x);
    end
  end

endmodule

// File: rtl/conv_stim_master.sv
// Stimulus master: issues N convolution operations to the core with a credit
// limit on outstanding operations, collects results and reports sum/cycles/error.
//
// state | meaning
// IDLE  | waiting for a start edge
// RUN   | issuing operands and collecting results
// DONE  | run complete, results held until the next start edge
module conv_stim_master
  import conv_pkg::*;
#(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                i_clk,
  input  logic                i_arstn,
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_count,
  input  logic [X_W-1:0]      i_seed,
  input  logic [X_W-1:0]      i_bit_K,
  conv_stim_master_if.master  core,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [31:0]         o_sum,
  output logic [31:0]         o_cycles
);

  localparam logic [3:0] CREDITS = 4'(MAX_OUT);

  state_t            state, state_nxt;
  logic              start_q, start_qq, start_edge;
  logic              run_load;
  logic [CNT_W-1:0]  count_q, issued, received;
  logic [3:0]        outstanding;
  logic [X_W-1:0]    kernel_q, x_cur;
  logic              op_hs, res_hs, res_ok, res_last;

  assign start_edge = start_q & ~start_qq;

  // o_valid depends only on registered state, never on i_ready
  assign core.o_valid = (state == RUN) && (issued < count_q) && (outstanding < CREDITS);
  assign core.o_ready = (state == RUN);
  assign core.o_bit_X = x_cur;
  assign core.o_bit_K = kernel_q;

  assign op_hs    = core.o_valid & core.i_ready;
  assign res_hs   = core.i_valid & core.o_ready;
  // A result with nothing outstanding is spurious and is discarded
  assign res_ok   = res_hs & (outstanding != '0);
  assign res_last = res_ok & ((received + CNT_W'(1)) == count_q);

  assign o_busy = (state == RUN);
  assign o_done = (state == DONE);

  // Register the start level once and keep one more stage for edge detection
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      start_q  <= 1'b0;
      start_qq <= 1'b0;
    end else begin
      start_q  <= i_start;
      start_qq <= start_q;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state; start edges are honoured only outside RUN
  always_comb begin
    state_nxt = state;
    run_load  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_edge) begin
          run_load  = 1'b1;
          state_nxt = (i_count != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (res_last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run counters, credit tracking, sum and sticky error
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      count_q     <= '0;
      kernel_q    <= '0;
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
      o_sum       <= '0;
      o_cycles    <= '0;
      o_err       <= 1'b0;
    end else if (run_load) begin
      count_q     <= i_count;
      kernel_q    <= i_bit_K;
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
      o_sum       <= '0;
      o_cycles    <= '0;
      o_err       <= 1'b0;
    end else if (state == RUN) begin
      if (o_cycles != '1) o_cycles <= o_cycles + 32'd1;
      if (op_hs) issued <= issued + CNT_W'(1);
      if (res_ok) begin
        o_sum    <= o_sum + 32'(core.i_conv);
        received <= received + CNT_W'(1);
      end
      if (res_hs && !res_ok) o_err <= 1'b1;
      case ({op_hs, res_ok})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  lfsr25 u_lfsr (
    .i_clk     (i_clk),
    .i_arstn   (i_arstn),
    .i_load    (run_load),
    .i_seed    (i_seed),
    .i_advance (op_hs),
    .o_x       (x_cur)
  );

endmodule

// File: tb/tb_conv_stim_master.sv
// Directed bench for conv_stim_master with a fixed-latency stub convolution core.
module tb_conv_stim_master;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] count = '0;
  logic [24:0] seed = '0;
  logic [24:0] kern = '0;
  logic        busy, done, err;
  logic [31:0] sum, cycles;

  conv_stim_master_if cif();

  conv_stim_master #(.MAX_OUT(2), .CNT_W(16)) dut (
    .i_clk    (clk),
    .i_arstn  (rst_n),
    .i_start  (start),
    .i_count  (count),
    .i_seed   (seed),
    .i_bit_K  (kern),
    .core     (cif),
    .o_busy   (busy),
    .o_done   (done),
    .o_err    (err),
    .o_sum    (sum),
    .o_cycles (cycles)
  );

  always #5 clk = ~clk;

  // Stub core state
  int          cyc = 0;
  int          lat = 3;
  logic [1:0]  conv_val = 2'd2;
  int          q_due[$];
  logic [1:0]  q_conv[$];
  logic [24:0] xlog[$];
  int          valid_cycles = 0;
  int          max_inflight = 0;
  int          outst_bad = 0;
  logic        stub_valid = 1'b0;
  logic [1:0]  stub_conv = 2'd0;
  logic        spur = 1'b0;

  int tests = 0;
  int fails = 0;

  assign cif.i_valid = stub_valid | spur;
  assign cif.i_conv  = stub_valid ? stub_conv : 2'd3;

  // Stub core: answers each accepted operand after lat cycles, in order
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q_due.delete();
      q_conv.delete();
    end else begin
      if (cif.o_valid) valid_cycles++;
      if (cif.o_valid && cif.i_ready) begin
        xlog.push_back(cif.o_bit_X);
        q_due.push_back(cyc + lat);
        q_conv.push_back(conv_val);
      end
      if (stub_valid && cif.o_ready) begin
        void'(q_due.pop_front());
        void'(q_conv.pop_front());
      end
    end
    #1;
    if (q_due.size() > max_inflight) max_inflight = q_due.size();
    if (busy && (int'(dut.outstanding) != q_due.size())) outst_bad++;
    stub_valid = (q_due.size() != 0) && (q_due[0] <= cyc);
    stub_conv  = stub_valid ? q_conv[0] : 2'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [15:0] c, input logic [24:0] s, input logic [24:0] k);
    start = 1'b0;
    tick(2);
    count = c;
    seed  = s;
    kern  = k;
    start = 1'b1;
    tick(2);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && !done; i++) tick(1);
    chk(tag, 32'(done), 32'd1);
  endtask

  function automatic logic [24:0] xat(input int idx);
    return (idx < xlog.size()) ? xlog[idx] : 'x;
  endfunction

  int b;
  int vb;

  initial begin
    cif.i_ready = 1'b0;
    tick(3);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_sum",   sum, 32'd0);
    chk("rst_cyc",   cycles, 32'd0);
    chk("rst_valid", 32'(cif.o_valid), 32'd0);
    chk("rst_ready", 32'(cif.o_ready), 32'd0);
    chk("rst_x",     32'(cif.o_bit_X), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic run: 4 ops, results after 3 cycles, includes a same-cycle dual handshake
    cif.i_ready = 1'b1;
    lat = 3;
    conv_val = 2'd2;
    b = xlog.size();
    start_run(16'd4, 25'h1, 25'h1FFFFFF);
    chk("basic_busy",  32'(busy), 32'd1);
    chk("basic_valid", 32'(cif.o_valid), 32'd1);
    chk("basic_x0",    32'(cif.o_bit_X), 32'h1);
    chk("basic_k",     32'(cif.o_bit_K), 32'h1FFFFFF);
    wait_done("basic_done");
    chk("basic_busy_low", 32'(busy), 32'd0);
    chk("basic_nops", 32'(xlog.size() - b), 32'd4);
    for (int i = 0; i < 4; i++) chk("basic_xseq", 32'(xat(b + i)), 32'd1 << i);
    chk("basic_sum", sum, 32'd8);
    chk("basic_err", 32'(err), 32'd0);
    chk("basic_cycles", cycles, 32'd11);

    // Credit limit: slow core, valid must drop after two operands
    lat = 10;
    conv_val = 2'd1;
    b = xlog.size();
    start_run(16'd3, 25'h5, 25'h0AAAAAA);
    chk("credit_valid0", 32'(cif.o_valid), 32'd1);
    tick(1);
    chk("credit_valid1", 32'(cif.o_valid), 32'd1);
    chk("credit_x1", 32'(cif.o_bit_X), 32'hA);
    tick(1);
    chk("credit_valid_drop", 32'(cif.o_valid), 32'd0);
    tick(5);
    chk("credit_valid_held", 32'(cif.o_valid), 32'd0);
    chk("credit_nops", 32'(xlog.size() - b), 32'd2);
    wait_done("credit_done");
    chk("credit_x2", 32'(xat(b + 2)), 32'h14);
    chk("credit_sum", sum, 32'd3);

    // Zero count: straight to DONE, no operand ever offered
    vb = valid_cycles;
    start_run(16'd0, 25'h7, 25'h1);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    tick(2);
    chk("zero_sum", sum, 32'd0);
    chk("zero_cycles", cycles, 32'd0);
    chk("zero_no_valid", 32'(valid_cycles - vb), 32'd0);

    // Spurious result with nothing outstanding
    cif.i_ready = 1'b0;
    lat = 6;
    conv_val = 2'd3;
    start_run(16'd2, 25'h1, 25'h1);
    chk("spur_busy", 32'(busy), 32'd1);
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    chk("spur_err", 32'(err), 32'd1);
    chk("spur_sum", sum, 32'd0);
    chk("spur_x_hold", 32'(cif.o_bit_X), 32'h1);
    cif.i_ready = 1'b1;
    tick(3);
    chk("spur_err_sticky", 32'(err), 32'd1);
    wait_done("spur_done");
    chk("spur_sum_final", sum, 32'd6);
    chk("spur_err_final", 32'(err), 32'd1);

    // Zero seed is replaced by 1; restart clears the sticky error
    lat = 1;
    conv_val = 2'd1;
    start_run(16'd1, 25'h0, 25'h123);
    chk("seed0_x", 32'(cif.o_bit_X), 32'h1);
    chk("seed0_err_clr", 32'(err), 32'd0);
    wait_done("seed0_done");
    chk("seed0_sum", sum, 32'd1);

    // Reset mid-run after five operands, then a fresh short run
    lat = 2;
    conv_val = 2'd2;
    b = xlog.size();
    start_run(16'd10, 25'h1, 25'h1FFFFFF);
    for (int i = 0; i < 100 && (xlog.size() - b) < 5; i++) tick(1);
    chk("rst_mid_ops", 32'((xlog.size() - b) >= 5), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_busy",  32'(busy), 32'd0);
    chk("mid_done",  32'(done), 32'd0);
    chk("mid_sum",   sum, 32'd0);
    chk("mid_cyc",   cycles, 32'd0);
    chk("mid_valid", 32'(cif.o_valid), 32'd0);
    chk("mid_x",     32'(cif.o_bit_X), 32'd0);
    chk("mid_k",     32'(cif.o_bit_K), 32'd0);
    start = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_idle", 32'(busy | done), 32'd0);
    start_run(16'd2, 25'h3, 25'h1);
    wait_done("post_rst_done");
    chk("post_rst_sum", sum, 32'd4);
    chk("post_rst_err", 32'(err), 32'd0);

    chk("credit_model", 32'(outst_bad), 32'd0);
    chk("max_inflight", 32'(max_inflight), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
